// File: rtl/toggle_cover_detector.sv
// rtl/toggle_cover_detector.sv - per-bit rise/fall toggle cover detector with sticky mask and hit counter
module toggle_cover_detector #(
    parameter int WIDTH    = 31,
    parameter int ONE_SHOT = 1,
    parameter int CNT_W    = $clog2(2*WIDTH+1)
) (
    input  logic                 gbl_clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 clear,
    input  logic [WIDTH-1:0]     sig,
    output logic [2*WIDTH-1:0]   valid,
    output logic [CNT_W-1:0]     hit_count,
    output logic                 all_hit
);

    typedef enum logic {PRIME = 1'b0, ARMED = 1'b1} state_t;

    state_t               r_state, w_nxt_state;
    logic [WIDTH-1:0]     r_prev, w_nxt_prev;
    logic [2*WIDTH-1:0]   r_covered, w_nxt_covered;
    logic [2*WIDTH-1:0]   r_valid, w_nxt_valid;
    logic [CNT_W-1:0]     r_hit_count, w_nxt_hit_count;
    logic                 r_all_hit, w_nxt_all_hit;

    logic [WIDTH-1:0]     w_rise, w_fall;
    logic [2*WIDTH-1:0]   w_ev, w_newhit;
    logic [CNT_W-1:0]     w_pop;

    assign w_rise   = ~r_prev & sig;
    assign w_fall   = r_prev & ~sig;
    assign w_newhit = w_ev & ~r_covered;

    // Even slot = rise, odd slot = fall; popcount is a flat adder over all cover points.
    always_comb begin
        w_ev  = '0;
        w_pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_ev[2*i]   = w_rise[i];
            w_ev[2*i+1] = w_fall[i];
        end
        for (int j = 0; j < 2*WIDTH; j++) begin
            w_pop = w_pop + CNT_W'(w_newhit[j]);
        end
    end

    always_comb begin
        w_nxt_state     = r_state;
        w_nxt_prev      = r_prev;
        w_nxt_covered   = r_covered;
        w_nxt_valid     = '0;
        w_nxt_hit_count = r_hit_count;
        w_nxt_all_hit   = r_all_hit;
        if (clear) begin
            w_nxt_covered   = '0;
            w_nxt_hit_count = '0;
            w_nxt_all_hit   = 1'b0;
            w_nxt_state     = PRIME;
        end else if (en) begin
            w_nxt_prev = sig;
            if (r_state == PRIME) begin
                w_nxt_state = ARMED;
            end else begin
                w_nxt_covered   = r_covered | w_ev;
                w_nxt_valid     = (ONE_SHOT != 0) ? w_newhit : w_ev;
                w_nxt_hit_count = r_hit_count + w_pop;
                // Sticky: covered never shrinks outside clear, so the count cannot pass full.
                w_nxt_all_hit   = r_all_hit | (w_nxt_hit_count == CNT_W'(2*WIDTH));
            end
        end
    end

    always_ff @(posedge gbl_clk) begin
        if (!reset) begin
            r_state     <= PRIME;
            r_prev      <= '0;
            r_covered   <= '0;
            r_valid     <= '0;
            r_hit_count <= '0;
            r_all_hit   <= 1'b0;
        end else begin
            r_state     <= w_nxt_state;
            r_prev      <= w_nxt_prev;
            r_covered   <= w_nxt_covered;
            r_valid     <= w_nxt_valid;
            r_hit_count <= w_nxt_hit_count;
            r_all_hit   <= w_nxt_all_hit;
        end
    end

    assign valid     = r_valid;
    assign hit_count = r_hit_count;
    assign all_hit   = r_all_hit;

endmodule

// File: tb/tb_toggle_cover_detector.sv
// tb/tb_toggle_cover_detector.sv - self-checking bench for toggle_cover_detector, one-shot and every-hit variants
module tb_toggle_cover_detector;

    localparam int W = 31;
    localparam int P = 2*W;

    logic          gbl_clk = 1'b0;
    logic          reset   = 1'b0;
    logic          en      = 1'b0;
    logic          clear   = 1'b0;
    logic [W-1:0]  sig     = '0;

    logic [P-1:0]  valid1, valid0;
    logic [5:0]    hit1, hit0;
    logic          all1, all0;

    int checks   = 0;
    int failures = 0;

    always #5 gbl_clk = ~gbl_clk;

    toggle_cover_detector #(.WIDTH(W), .ONE_SHOT(1)) u_dut1 (
        .gbl_clk(gbl_clk), .reset(reset), .en(en), .clear(clear), .sig(sig),
        .valid(valid1), .hit_count(hit1), .all_hit(all1)
    );

    toggle_cover_detector #(.WIDTH(W), .ONE_SHOT(0)) u_dut0 (
        .gbl_clk(gbl_clk), .reset(reset), .en(en), .clear(clear), .sig(sig),
        .valid(valid0), .hit_count(hit0), .all_hit(all0)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks the set of cover points seen and the last sampled vector.
    bit          m_live   = 1'b0;
    bit          m_primed = 1'b0;
    logic [W-1:0] m_prev  = '0;
    bit          m_seen[int];
    logic [P-1:0] m_ev, m_new;

    always @(posedge gbl_clk) begin
        m_ev  = '0;
        m_new = '0;
        if (!reset) begin
            m_live   = 1'b1;
            m_primed = 1'b0;
            m_seen.delete();
        end else if (clear) begin
            m_primed = 1'b0;
            m_seen.delete();
        end else if (en) begin
            if (m_primed) begin
                for (int i = 0; i < W; i++) begin
                    int p;
                    p = -1;
                    if (!m_prev[i] && sig[i]) p = 2*i;
                    if (m_prev[i] && !sig[i]) p = 2*i + 1;
                    if (p >= 0) begin
                        m_ev[p] = 1'b1;
                        if (!m_seen.exists(p)) begin
                            m_new[p]  = 1'b1;
                            m_seen[p] = 1'b1;
                        end
                    end
                end
            end
            m_prev   = sig;
            m_primed = 1'b1;
        end
        #1;
        if (m_live) begin
            chk("valid_oneshot", 64'(valid1), 64'(m_new));
            chk("valid_every",   64'(valid0), 64'(m_ev));
            chk("hit_oneshot",   64'(hit1),   64'(m_seen.num()));
            chk("hit_every",     64'(hit0),   64'(m_seen.num()));
            chk("all_oneshot",   64'(all1),   64'(m_seen.num() == P));
            chk("all_every",     64'(all0),   64'(m_seen.num() == P));
        end
    end

    task automatic step(input logic rs, input logic e, input logic c, input logic [W-1:0] s);
        @(negedge gbl_clk);
        reset = rs;
        en    = e;
        clear = c;
        sig   = s;
        @(posedge gbl_clk);
        #2;
    endtask

    initial begin
        logic [W-1:0] s;

        // Reset and priming
        step(0, 1, 0, '0);
        step(0, 1, 0, '0);
        chk("rst_valid", 64'(valid1), 64'h0);
        chk("rst_hit",   64'(hit1),   64'h0);
        chk("rst_all",   64'(all1),   64'h0);
        step(1, 1, 0, 31'h7FFF_FFFF);
        chk("prime_nopulse", 64'(valid1), 64'h0);

        // Single-bit toggle
        step(0, 1, 0, '0);
        step(1, 1, 0, '0);
        step(1, 1, 0, 31'h1);
        chk("b0_rise",     64'(valid1), 64'h1);
        chk("b0_rise_hit", 64'(hit1),   64'd1);
        step(1, 1, 0, 31'h0);
        chk("b0_fall",     64'(valid1), 64'h2);
        chk("b0_fall_hit", 64'(hit1),   64'd2);
        step(1, 1, 0, 31'h1);
        chk("b0_rerise",     64'(valid1), 64'h0);
        chk("b0_rerise_hit", 64'(hit1),   64'd2);

        // Clear mid-run
        step(1, 1, 1, 31'h0);
        chk("clr_hit",   64'(hit1),   64'd0);
        chk("clr_valid", 64'(valid1), 64'h0);
        step(1, 1, 0, 31'h0);
        chk("clr_prime", 64'(valid1), 64'h0);
        step(1, 1, 0, 31'h1);
        chk("clr_rise",     64'(valid1), 64'h1);
        chk("clr_rise_hit", 64'(hit1),   64'd1);

        // All bits, both directions
        step(0, 1, 0, '0);
        step(1, 1, 0, '0);
        step(1, 1, 0, 31'h7FFF_FFFF);
        chk("all_rise",     64'(valid1), 64'h1555_5555_5555_5555);
        chk("all_rise_hit", 64'(hit1),   64'd31);
        chk("all_rise_flag", 64'(all1),  64'h0);
        step(1, 1, 0, 31'h0);
        chk("all_fall",     64'(valid1), 64'h2AAA_AAAA_AAAA_AAAA);
        chk("all_fall_hit", 64'(hit1),   64'd62);
        chk("all_fall_flag", 64'(all1),  64'h1);

        // Enable gating
        step(0, 1, 0, '0);
        step(1, 1, 0, '0);
        step(1, 0, 0, 31'h8);
        step(1, 0, 0, 31'h8);
        chk("gate_hold", 64'(valid1), 64'h0);
        step(1, 1, 0, 31'h8);
        chk("gate_b3", 64'(valid1), 64'h40);
        step(1, 0, 0, 31'h28);
        step(1, 0, 0, 31'h8);
        step(1, 1, 0, 31'h8);
        chk("gate_glitch", 64'(valid1), 64'h0);

        // Every-hit variant and reset during a toggle
        step(0, 1, 0, '0);
        step(1, 1, 0, '0);
        for (int k = 0; k < 3; k++) begin
            step(1, 1, 0, 31'h4);
            chk("every_b2_rise", 64'(valid0), 64'h10);
            if (k == 0) chk("every_b2_hit", 64'(hit0), 64'd1);
            step(1, 1, 0, 31'h0);
        end
        chk("every_b2_hit_end", 64'(hit0), 64'd2);
        step(0, 1, 0, 31'h4);
        chk("rst_toggle_valid", 64'(valid0), 64'h0);
        chk("rst_toggle_hit",   64'(hit0),   64'd0);

        // Randomized run with sparse toggles; the model process checks every cycle.
        s = '0;
        for (int n = 0; n < 4000; n++) begin
            logic rs, e, c;
            rs = ($urandom_range(0, 299) != 0);
            c  = ($urandom_range(0, 149) == 0);
            e  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) s = W'($urandom);
            else s = s ^ W'($urandom & $urandom & $urandom);
            step(rs, e, c, s);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
